// File: rtl/inbuf_pkg.sv
// Shared types and helpers for the input-buffer prefetch controller.
package inbuf_pkg;

    localparam int unsigned STALL_W_DEF = 16;
    localparam int unsigned LANE_W_DEF  = 32;

    typedef logic [LANE_W_DEF-1:0] lane_data_t;

    // Encoding equals the number of valid lines held (active + shadow).
    typedef enum logic [1:0] {
        EMPTY       = 2'd0,
        ACTIVE_ONLY = 2'd1,
        BOTH        = 2'd2
    } slot_state_t;

    function automatic int unsigned clamp_m(input int unsigned m, input int unsigned m_max);
        if (m < 2) return 2;
        if (m > m_max) return m_max;
        return m;
    endfunction

endpackage

// File: rtl/inbuf_use_counter.sv
// Counts engine uses of the active line against a latched per-line limit.
module inbuf_use_counter #(
    parameter int unsigned M_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr_i,
    input  logic           load_i,
    input  logic [M_W-1:0] lim_i,
    input  logic           inc_i,
    input  logic           val_d_i,
    output logic           last_use_o,
    output logic           retire_c_o
);

    logic [M_W-1:0] cnt_q, cnt_d;
    logic [M_W-1:0] lim_q, lim_d;
    logic           last_q, last_d;

    assign retire_c_o = inc_i & last_q;
    assign last_use_o = last_q;

    // last_use is precomputed from next-state so it is a plain flop output.
    always_comb begin
        lim_d  = load_i ? lim_i : lim_q;
        cnt_d  = cnt_q;
        if (retire_c_o) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + M_W'(1);
        end
        last_d = val_d_i & (cnt_d == M_W'(lim_d - M_W'(1)));
        if (clr_i) begin
            lim_d  = '0;
            cnt_d  = '0;
            last_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            lim_q  <= '0;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lim_q  <= lim_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/inbuf_prefetch_cntl.sv
// Multi-lane input-buffer controller: active/shadow line buffer with prefetch,
// per-line use counting, underrun and stall accounting.
module inbuf_prefetch_cntl
    import inbuf_pkg::*;
#(
    parameter int unsigned LANES   = 4,
    parameter int unsigned LANE_W  = LANE_W_DEF,
    parameter int unsigned M_MAX   = 128,
    parameter int unsigned M_W     = $clog2(M_MAX + 1),
    parameter int unsigned STALL_W = STALL_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    eng_rst,
    input  logic                    cntl_en,
    input  logic [M_W-1:0]          m_reg,
    input  logic [LANES-1:0]        fifo_empty,
    output logic [LANES-1:0]        fifo_rd_rq,
    input  logic [LANES*LANE_W-1:0] fifo_rd_data,
    output logic [LANES*LANE_W-1:0] eng_data,
    output logic                    eng_data_val,
    input  logic                    eng_data_used,
    output logic                    eng_last_use,
    output logic [STALL_W-1:0]      stall_cnt,
    output logic                    err_underrun,
    output logic                    busy
);

    localparam int unsigned DATA_W = LANES * LANE_W;

    slot_state_t        slot_q, slot_d;
    logic [DATA_W-1:0]  act_q, act_d, shd_q, shd_d;
    logic               inflight_q, inflight_d;
    logic               cntl_en_q;
    logic               first_seen_q, first_seen_d;
    logic               err_q, err_d;
    logic               val_q, busy_q;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic               rd_c, rise_c, inc_c, retire_c, room_c;
    logic [1:0]         occ_c, rem_c, cnt_d;
    logic [M_W-1:0]     lim_c;

    assign rise_c = cntl_en & ~cntl_en_q;
    assign inc_c  = eng_data_used & val_q;
    assign lim_c  = M_W'(clamp_m(32'(m_reg), M_MAX));
    assign occ_c  = 2'(slot_q) + {1'b0, inflight_q};
    assign rem_c  = 2'(slot_q) - {1'b0, retire_c};

    // A free slot exists when occupancy (lines + in-flight) minus a retiring line is below two.
    assign room_c     = {1'b0, occ_c} < (3'd2 + {2'b0, retire_c});
    assign rd_c       = cntl_en & ~(|fifo_empty) & room_c & ~eng_rst;
    assign fifo_rd_rq = {LANES{rd_c}};

    inbuf_use_counter #(.M_W(M_W)) u_use_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (eng_rst),
        .load_i     (rise_c),
        .lim_i      (lim_c),
        .inc_i      (inc_c),
        .val_d_i    (slot_d != EMPTY),
        .last_use_o (eng_last_use),
        .retire_c_o (retire_c)
    );

    always_comb begin
        act_d        = act_q;
        shd_d        = shd_q;
        cnt_d        = rem_c;
        inflight_d   = rd_c;
        first_seen_d = first_seen_q | inflight_q;
        err_d        = err_q | (eng_data_used & ~val_q);
        stall_d      = stall_q;
        if (retire_c && (slot_q == BOTH)) begin
            act_d = shd_q;
        end
        // Landing line fills active if nothing remains after retire, else shadow.
        if (inflight_q) begin
            cnt_d = rem_c + 2'd1;
            if (rem_c == 2'd0) begin
                act_d = fifo_rd_data;
            end else begin
                shd_d = fifo_rd_data;
            end
        end
        slot_d = slot_state_t'(cnt_d);
        if (cntl_en && !val_q && first_seen_q && !(&stall_q)) begin
            stall_d = stall_q + STALL_W'(1);
        end
        if (eng_rst) begin
            slot_d       = EMPTY;
            inflight_d   = 1'b0;
            first_seen_d = 1'b0;
            err_d        = 1'b0;
            stall_d      = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q       <= EMPTY;
            act_q        <= '0;
            shd_q        <= '0;
            inflight_q   <= 1'b0;
            cntl_en_q    <= 1'b0;
            first_seen_q <= 1'b0;
            err_q        <= 1'b0;
            stall_q      <= '0;
            val_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            act_q        <= act_d;
            shd_q        <= shd_d;
            inflight_q   <= inflight_d;
            cntl_en_q    <= cntl_en & ~eng_rst;
            first_seen_q <= first_seen_d;
            err_q        <= err_d;
            stall_q      <= stall_d;
            val_q        <= (slot_d != EMPTY);
            busy_q       <= (slot_d != EMPTY) | inflight_d;
        end
    end

    assign eng_data     = act_q;
    assign eng_data_val = val_q;
    assign stall_cnt    = stall_q;
    assign err_underrun = err_q;
    assign busy         = busy_q;

endmodule
